// File: rtl/display_pkg.sv
// Shared constants for seven-segment display blocks: active-low glyphs
// (bit 0 = segment a ... bit 6 = segment g) and the digit-index width helper.
package display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] HEX_GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // A single-digit display still needs a one-bit index register.
  function automatic int digit_idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex nibble to active-low seven-segment glyph decoder.
module seg7_hex_decoder
  import display_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] segments_o
);

  assign segments_o = HEX_GLYPH[nibble_i];

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed seven-segment scanner with per-frame input shadowing.
// Define SEVEN_SEG_LEADING_ZERO_BLANK_EN to darken leading zero digits.
module seven_seg_scanner
  import display_pkg::*;
#(
  parameter int N_DIGITS = 8,
  parameter int PRESCALE = 100000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp_in,
  output logic [6:0]            segments,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   anodos,
  output logic                  frame_done
);

  localparam int PW = $clog2(PRESCALE);
  localparam int IW = digit_idx_width(N_DIGITS);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);

  logic [PW-1:0]         preCount_q, preCount_d;
  logic [IW-1:0]         digitIdx_q, digitIdx_d;
  logic [4*N_DIGITS-1:0] shadowVal_q, shadowVal_d;
  logic [N_DIGITS-1:0]   shadowDp_q, shadowDp_d;
  logic [6:0]            segments_q, segments_d;
  logic                  dp_q, dp_d;
  logic [N_DIGITS-1:0]   anodes_q, anodes_d;
  logic                  frameDone_q, frameDone_d;

  logic       tick;
  logic       wrap;
  logic [3:0] nibbleSel;
  logic       dpSel;
  logic       blankSel;
  logic [6:0] glyph;

  always_comb begin
    tick        = enable && (preCount_q == PRE_LAST);
    wrap        = tick && (digitIdx_q == IDX_LAST);
    preCount_d  = preCount_q;
    digitIdx_d  = digitIdx_q;
    shadowVal_d = shadowVal_q;
    shadowDp_d  = shadowDp_q;
    frameDone_d = wrap;
    if (enable) begin
      preCount_d = tick ? '0 : preCount_q + 1'b1;
    end
    if (tick) begin
      digitIdx_d = wrap ? '0 : digitIdx_q + 1'b1;
    end
    // Inputs are only sampled at frame boundaries so a frame is never torn.
    if (wrap) begin
      shadowVal_d = value;
      shadowDp_d  = dp_in;
    end
  end

  always_comb begin
    nibbleSel = '0;
    dpSel     = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (digitIdx_q == IW'(i)) begin
        nibbleSel = shadowVal_q[4*i +: 4];
        dpSel     = shadowDp_q[i];
      end
    end
  end

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  logic upperZero;

  // Walk from the most significant digit down; digit 0 is never blanked.
  always_comb begin
    blankSel  = 1'b0;
    upperZero = 1'b1;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      upperZero = upperZero && (shadowVal_q[4*i +: 4] == 4'h0);
      if (digitIdx_q == IW'(i)) begin
        blankSel = upperZero && !shadowDp_q[i];
      end
    end
  end
`else
  assign blankSel = 1'b0;
`endif

  seg7_hex_decoder u_decoder (
    .nibble_i   (nibbleSel),
    .segments_o (glyph)
  );

  always_comb begin
    anodes_d   = '1;
    segments_d = SEG_BLANK;
    dp_d       = 1'b1;
    if (enable && !blankSel) begin
      for (int i = 0; i < N_DIGITS; i++) begin
        anodes_d[i] = (digitIdx_q != IW'(i));
      end
      segments_d = glyph;
      dp_d       = ~dpSel;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      preCount_q  <= '0;
      digitIdx_q  <= '0;
      shadowVal_q <= '0;
      shadowDp_q  <= '0;
      segments_q  <= SEG_BLANK;
      dp_q        <= 1'b1;
      anodes_q    <= '1;
      frameDone_q <= 1'b0;
    end else begin
      preCount_q  <= preCount_d;
      digitIdx_q  <= digitIdx_d;
      shadowVal_q <= shadowVal_d;
      shadowDp_q  <= shadowDp_d;
      segments_q  <= segments_d;
      dp_q        <= dp_d;
      anodes_q    <= anodes_d;
      frameDone_q <= frameDone_d;
    end
  end

  assign segments   = segments_q;
  assign dp         = dp_q;
  assign anodos     = anodes_q;
  assign frame_done = frameDone_q;

endmodule

// File: doc/seven_seg_scanner.md
SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 SHALL have parameter N_DIGITS, default 8, the number of multiplexed digits (legal 1..8).
REQ-002 SHALL have parameter PRESCALE, default 100000, the clock cycles per digit slot (legal >= 2).
REQ-003 SHALL have port clock  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port enable  input  1  high = scan and display; low = display dark, scan frozen.
REQ-006 SHALL have port value  input  4*N_DIGITS  hex nibbles; nibble i drives digit i, digit 0 least significant.
REQ-007 SHALL have port dp_in  input  N_DIGITS  decimal point request per digit.
REQ-008 SHALL have port segments  output  7  active-low segments, bit 0 = a through bit 6 = g.
REQ-009 SHALL have port dp  output  1  active-low decimal point.
REQ-010 SHALL have port anodos  output  N_DIGITS  active-low digit enables; at most one bit low at any time.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse at each frame wrap.

Function
REQ-012 SHALL run a prescaler counting 0..PRESCALE-1 while enable is high; terminal count asserts an internal tick and wraps to 0.
REQ-013 SHALL advance the digit index by 1 on each tick, wrapping from N_DIGITS-1 to 0.
REQ-014 SHALL capture value and dp_in into a shadow register on the tick that wraps the index to 0; mid-frame input changes have no visible effect until the next frame.
REQ-015 SHALL pulse frame_done for exactly one cycle, coincident with the shadow capture.
REQ-016 SHALL register segments, dp and anodos; outputs reflect a new index one cycle after the tick.
REQ-017 SHALL drive anodos bit[index] low and all other bits high, segments = hex glyph of shadow nibble[index], dp = ~shadow_dp[index].
REQ-018 SHALL decode nibbles 0x0..0xF to glyphs 0-9, A, b, C, d, E, F.
REQ-019 SHALL, while enable is low, hold prescaler and index, drive anodos all ones, segments 7'h7F, dp 1, frame_done 0.
REQ-020 SHALL, on enable rising, resume from the held prescaler and index with no lost or repeated digit slot.
REQ-021 SHALL, when N_DIGITS = 1, tick every PRESCALE cycles and pulse frame_done on every tick.

Reset
REQ-022 SHALL, on reset low, asynchronously clear prescaler, index and shadow to 0 and set anodos all ones, segments 7'h7F, dp 1, frame_done 0.
REQ-023 SHALL, on reset deassertion mid-frame, restart at digit 0 displaying the zeroed shadow until the first frame wrap.

Configuration
REQ-024 SHALL compile leading-zero blanking when macro SEVEN_SEG_LEADING_ZERO_BLANK_EN is defined.
REQ-025 SHALL, with the macro defined, hold digit i > 0 dark (anode high, segments 7'h7F, dp 1) when shadow nibbles i..N_DIGITS-1 are all zero and shadow_dp[i] is 0; digit 0 is never blanked.
REQ-026 SHALL, without the macro, display every digit including leading zeros; slot timing is identical in both builds.

Structure
REQ-027 SHALL place the glyph constants (SEG_BLANK = 7'h7F, the 16 hex glyphs) and the digit-index width function in shared package display_pkg.
REQ-028 SHALL implement nibble-to-glyph decoding in combinational sub-module seg7_hex_decoder, instantiated once.

Verification (N_DIGITS=4, PRESCALE=4 unless stated)
REQ-029 SHALL verify reset: reset low mid-scan -> anodos 4'hF, segments 7'h7F, dp 1 within the same cycle; after release, digit 0 shows glyph 0 (7'h40).
REQ-030 SHALL verify scan: value 16'h12AF, enable 1 -> anodos 1110, 1101, 1011, 0111 each for 4 cycles showing F, A, 2, 1; frame_done once per 16 cycles.
REQ-031 SHALL verify shadowing: value changes 16'h12AF -> 16'h0000 while index = 1 -> digits 2 and 3 still show 2 and 1; zeros appear only after frame_done.
REQ-032 SHALL verify enable: enable low for 10 cycles at index 2 -> anodos 4'hF throughout; on re-enable, digit 2 completes its remaining prescaler count before digit 3.
REQ-033 SHALL verify blanking: value 16'h0050 with the macro -> digits 3 and 2 dark, digits 1 and 0 show 5 and 0; without the macro all four digits lit.
REQ-034 SHALL verify dp and N_DIGITS=1: dp_in 4'b0100 -> dp low only while anodos = 1011; N_DIGITS=1 build -> anodos constantly 0, frame_done every 4 cycles.
